// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side SRAM-like buses: source tags,
// transfer size encodings and address width.
package cpu_bus_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_tag_fifo.sv
// Small synchronous FIFO with a combinational head, used to remember which
// master owns each outstanding transaction.
module sram_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Merges the instruction and data SRAM-like masters onto one slave port with
// data priority, grant lock until accept, and in-order response steering.
module sram_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [3:0]        inst_sram_wstrb,
  input  logic [31:0]       inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [31:0]       inst_sram_rdata,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata,
  output logic              protocol_err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic             r_lock;
  src_e             r_lock_src;
  logic             r_perr;
  src_e             w_grant_src;
  logic             w_grant_req;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic             w_head;
  logic [CNT_W-1:0] w_count_unused;

  // With no lock and no data request the mux defaults to INST, so an idle
  // instruction master simply yields grant_req = 0.
  always_comb begin
    w_grant_src = SRC_INST;
    if (r_lock)             w_grant_src = r_lock_src;
    else if (data_sram_req) w_grant_src = SRC_DATA;
    w_grant_req = (w_grant_src == SRC_DATA) ? data_sram_req : inst_sram_req;
  end

  always_comb begin
    mem_wr    = inst_sram_wr;
    mem_size  = inst_sram_size;
    mem_addr  = inst_sram_addr;
    mem_wstrb = inst_sram_wstrb;
    mem_wdata = inst_sram_wdata;
    if (w_grant_src == SRC_DATA) begin
      mem_wr    = data_sram_wr;
      mem_size  = data_sram_size;
      mem_addr  = data_sram_addr;
      mem_wstrb = data_sram_wstrb;
      mem_wdata = data_sram_wdata;
    end
  end

  assign mem_req           = w_grant_req && !w_full;
  assign w_accept          = mem_req && mem_addr_ok;
  assign inst_sram_addr_ok = w_accept && (w_grant_src == SRC_INST);
  assign data_sram_addr_ok = w_accept && (w_grant_src == SRC_DATA);

  assign inst_sram_data_ok = mem_data_ok && !w_empty && (w_head == SRC_INST);
  assign data_sram_data_ok = mem_data_ok && !w_empty && (w_head == SRC_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;
  assign protocol_err      = r_perr;

  // Lock follows an offered-but-unaccepted request; a dropped req or an
  // accept both leave mem_req && !mem_addr_ok false, which clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock     <= 1'b0;
      r_lock_src <= SRC_INST;
      r_perr     <= 1'b0;
    end else begin
      r_lock     <= mem_req && !mem_addr_ok;
      r_lock_src <= w_grant_src;
      if (mem_data_ok && w_empty) r_perr <= 1'b1;
    end
  end

  sram_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_accept),
    .din    (w_grant_src),
    .pop    (mem_data_ok),
    .head   (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count_unused)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: a cycle table covering grant, lock,
// full and steering, plus hand sequences for reset and protocol_err.
module tb_sram_bus_arbiter;
  import cpu_bus_pkg::*;

  localparam logic [31:0] I_ADDR  = 32'hBFC0_0000;
  localparam logic [31:0] D_ADDR  = 32'h0000_1000;
  localparam logic [31:0] D_WDATA = 32'hA5A5_A5A5;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [3:0]  inst_sram_wstrb;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  data_sram_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, protocol_err;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;

  sram_bus_arbiter #(.MAX_OUT(4)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_addr          (mem_addr),
    .mem_wstrb         (mem_wstrb),
    .mem_wdata         (mem_wdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata),
    .protocol_err      (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        d_req, i_req, aok, dok;
    logic [31:0] rdata;
    logic        e_req, e_dsel, e_iaok, e_daok, e_idok, e_ddok, e_perr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic dr, ir, ak, dk, input logic [31:0] rd,
                              input logic er, es, eia, eda, eid, edd, ep);
    vec_t v;
    v.d_req = dr; v.i_req = ir; v.aok = ak; v.dok = dk; v.rdata = rd;
    v.e_req = er; v.e_dsel = es; v.e_iaok = eia; v.e_daok = eda;
    v.e_idok = eid; v.e_ddok = edd; v.e_perr = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic dr, ir, ak, dk, input logic [31:0] rd);
    data_sram_req = dr;
    inst_sram_req = ir;
    mem_addr_ok   = ak;
    mem_data_ok   = dk;
    mem_rdata     = rd;
  endtask

  initial begin
    inst_sram_wr = 1'b0;  inst_sram_size = SIZE_W; inst_sram_addr = I_ADDR;
    inst_sram_wstrb = 4'h0; inst_sram_wdata = 32'h0;
    data_sram_wr = 1'b1;  data_sram_size = SIZE_B; data_sram_addr = D_ADDR;
    data_sram_wstrb = 4'h1; data_sram_wdata = D_WDATA;

    // Cycle table: d_req i_req aok dok rdata | req dsel iaok daok idok ddok perr
    vq.push_back(mk(0,1,0,0,32'h0,        1,0,0,0,0,0,0)); // single inst read
    vq.push_back(mk(0,1,0,0,32'h0,        1,0,0,0,0,0,0));
    vq.push_back(mk(0,1,1,0,32'h0,        1,0,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,32'h3C010000, 0,0,0,0,1,0,0));
    vq.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,0,0,0));
    vq.push_back(mk(1,1,1,0,32'h0,        1,1,0,1,0,0,0)); // simultaneous
    vq.push_back(mk(0,1,1,0,32'h0,        1,0,1,0,0,0,0));
    vq.push_back(mk(0,0,0,1,32'h11111111, 0,0,0,0,0,1,0));
    vq.push_back(mk(0,0,0,1,32'h22222222, 0,0,0,0,1,0,0));
    vq.push_back(mk(1,0,0,0,32'h0,        1,1,0,0,0,0,0)); // lock on DATA
    vq.push_back(mk(1,1,0,0,32'h0,        1,1,0,0,0,0,0));
    vq.push_back(mk(1,1,0,0,32'h0,        1,1,0,0,0,0,0));
    vq.push_back(mk(1,1,1,0,32'h0,        1,1,0,1,0,0,0));
    vq.push_back(mk(0,1,1,0,32'h0,        1,0,1,0,0,0,0));
    vq.push_back(mk(0,0,0,1,32'h33333333, 0,0,0,0,0,1,0));
    vq.push_back(mk(0,0,0,1,32'h44444444, 0,0,0,0,1,0,0));
    vq.push_back(mk(0,1,1,0,32'h0,        1,0,1,0,0,0,0)); // I D I D -> full
    vq.push_back(mk(1,0,1,0,32'h0,        1,1,0,1,0,0,0));
    vq.push_back(mk(0,1,1,0,32'h0,        1,0,1,0,0,0,0));
    vq.push_back(mk(1,0,1,0,32'h0,        1,1,0,1,0,0,0));
    vq.push_back(mk(0,1,1,0,32'h0,        0,0,0,0,0,0,0)); // full blocks
    vq.push_back(mk(0,1,1,1,32'h55555555, 0,0,0,0,1,0,0)); // pop while full
    vq.push_back(mk(0,1,1,1,32'h66666666, 1,0,1,0,0,1,0)); // push+pop
    vq.push_back(mk(0,0,0,1,32'h77777777, 0,0,0,0,1,0,0));
    vq.push_back(mk(0,0,0,1,32'h88888888, 0,0,0,0,0,1,0));
    vq.push_back(mk(0,0,0,1,32'h99999999, 0,0,0,0,1,0,0));
    vq.push_back(mk(0,1,0,0,32'h0,        1,0,0,0,0,0,0)); // lock INST
    vq.push_back(mk(1,0,0,0,32'h0,        0,0,0,0,0,0,0)); // locked INST drops
    vq.push_back(mk(1,0,1,0,32'h0,        1,1,0,1,0,0,0));
    vq.push_back(mk(0,0,0,1,32'hAAAA0000, 0,0,0,0,0,1,0));
    vq.push_back(mk(0,0,0,1,32'hDEAD0000, 0,0,0,0,0,0,0)); // spurious
    vq.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,0,0,1));

    // Reset state, including a data_ok arriving while reset is held.
    resetn = 1'b0;
    drive(0, 0, 0, 1, 32'h0);
    #12;
    chk("rst_mem_req", -1, 32'(mem_req), 32'h0);
    chk("rst_iaok",    -1, 32'(inst_sram_addr_ok), 32'h0);
    chk("rst_daok",    -1, 32'(data_sram_addr_ok), 32'h0);
    chk("rst_idok",    -1, 32'(inst_sram_data_ok), 32'h0);
    chk("rst_ddok",    -1, 32'(data_sram_data_ok), 32'h0);
    chk("rst_perr",    -1, 32'(protocol_err), 32'h0);
    @(negedge clk);
    mem_data_ok = 1'b0;
    resetn = 1'b1;

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].d_req, vq[k].i_req, vq[k].aok, vq[k].dok, vq[k].rdata);
      #1;
      $display("step %0d: dreq=%0b ireq=%0b aok=%0b dok=%0b -> mem_req=%0b addr=%h iaok=%0b daok=%0b idok=%0b ddok=%0b perr=%0b",
               k, vq[k].d_req, vq[k].i_req, vq[k].aok, vq[k].dok, mem_req, mem_addr,
               inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok,
               data_sram_data_ok, protocol_err);
      chk("mem_req", k, 32'(mem_req), 32'(vq[k].e_req));
      if (vq[k].e_req) begin
        chk("mem_addr",  k, mem_addr, vq[k].e_dsel ? D_ADDR : I_ADDR);
        chk("mem_wr",    k, 32'(mem_wr), 32'(vq[k].e_dsel));
        chk("mem_wdata", k, mem_wdata, vq[k].e_dsel ? D_WDATA : 32'h0);
        chk("mem_wstrb", k, 32'(mem_wstrb), vq[k].e_dsel ? 32'h1 : 32'h0);
        chk("mem_size",  k, 32'(mem_size), vq[k].e_dsel ? 32'(SIZE_B) : 32'(SIZE_W));
      end
      chk("inst_addr_ok", k, 32'(inst_sram_addr_ok), 32'(vq[k].e_iaok));
      chk("data_addr_ok", k, 32'(data_sram_addr_ok), 32'(vq[k].e_daok));
      chk("inst_data_ok", k, 32'(inst_sram_data_ok), 32'(vq[k].e_idok));
      chk("data_data_ok", k, 32'(data_sram_data_ok), 32'(vq[k].e_ddok));
      chk("protocol_err", k, 32'(protocol_err), 32'(vq[k].e_perr));
      if (vq[k].dok) begin
        chk("inst_rdata", k, inst_sram_rdata, vq[k].rdata);
        chk("data_rdata", k, data_sram_rdata, vq[k].rdata);
      end
    end

    // Outstanding tag, then asynchronous reset mid-cycle clears everything.
    @(negedge clk);
    drive(0, 1, 1, 0, 32'h0);
    #1;
    chk("pre_rst_iaok", 100, 32'(inst_sram_addr_ok), 32'h1);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0);
    #1;
    chk("pre_rst_perr", 101, 32'(protocol_err), 32'h1);
    #1;
    resetn = 1'b0;
    #1;
    $display("async reset asserted: perr=%0b", protocol_err);
    chk("async_rst_perr", 102, 32'(protocol_err), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 1, 32'hBEEF0000);
    #1;
    chk("discarded_idok", 103, 32'(inst_sram_data_ok), 32'h0);
    chk("discarded_ddok", 103, 32'(data_sram_data_ok), 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0);
    #1;
    chk("post_rst_perr", 104, 32'(protocol_err), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
